// File: rtl/aes_round_key_store.sv
// rtl/aes_round_key_store.sv - AES key expansion with stored schedule and streamed round-key read port
//
// Expands a 128/192/256-bit cipher key one schedule word per clock into an
// internal word store. The round keys are then streamed out, forward
// (round 0..Nr) or reverse (round Nr..0), over a valid/ready handshake.
//
// Build option: define AES_KEY_ZEROIZE_EN to clear the stored schedule when
// the final key of a read pass is accepted. A new load is then needed before
// the next pass. Without it the schedule is kept for any number of passes.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset
//   key_in    cipher key, first key byte in the MSBs, sampled with load
//   load      start expansion of key_in (aborts any expansion or read pass)
//   rd_start  start a read pass (honoured only when ready)
//   rd_dir    read order sampled with rd_start: 0 forward, 1 reverse
//   rk_ready  consumer accepts rk_out this cycle
//   busy      expansion in progress
//   ready     schedule complete and no read pass active
//   rk_valid  rk_out / rk_index / rk_last valid
//   rk_out    round key, word 4r in bits [127:96]
//   rk_index  round number of rk_out
//   rk_last   rk_out is the final key of the pass
module aes_round_key_store #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic                load,
    input  logic                rd_start,
    input  logic                rd_dir,
    input  logic                rk_ready,
    output logic                busy,
    output logic                ready,
    output logic                rk_valid,
    output logic [127:0]        rk_out,
    output logic [3:0]          rk_index,
    output logic                rk_last
);
    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXPAND = 2'd1;
    localparam logic [1:0] S_READY  = 2'd2;
    localparam logic [1:0] S_READ   = 2'd3;

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    logic [1:0]   state_q;
    logic [31:0]  w_q [NW];
    logic [5:0]   i_q;       // schedule word being produced
    logic [2:0]   mod_q;     // i_q mod Nk, kept as a counter to avoid a divider
    logic [7:0]   rcon_q;    // Rcon for the next i_q mod Nk == 0 word
    logic         dir_q;
    logic         busy_q;
    logic         ready_q;
    logic         rk_valid_q;
    logic         rk_last_q;
    logic [127:0] rk_out_q;
    logic [3:0]   rk_index_q;

    logic [31:0]  w_prev;
    logic [31:0]  w_old;
    logic [31:0]  w_tmp;
    logic [31:0]  w_new;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;
    logic         rd_is_last;

    always_comb begin
        w_prev = w_q[i_q - 6'd1];
        w_old  = w_q[i_q - 6'(NK)];
        if (mod_q == 3'd0) begin
            w_tmp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon_q, 24'h000000};
        end else if (NK == 8 && mod_q == 3'd4) begin
            w_tmp = sub_word(w_prev);
        end else begin
            w_tmp = w_prev;
        end
        w_new = w_old ^ w_tmp;

        // Outside READ this selects the first key of a pass about to start;
        // inside READ it selects the key following the one being presented.
        if (state_q == S_READ) begin
            rd_round = dir_q ? (rk_index_q - 4'd1) : (rk_index_q + 4'd1);
        end else begin
            rd_round = rd_dir ? 4'(NR) : 4'd0;
        end
        rd_key = {w_q[{rd_round, 2'b00}], w_q[{rd_round, 2'b01}],
                  w_q[{rd_round, 2'b10}], w_q[{rd_round, 2'b11}]};
        rd_is_last = dir_q ? (rd_round == 4'd0) : (rd_round == 4'(NR));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            i_q        <= 6'd0;
            mod_q      <= 3'd0;
            rcon_q     <= 8'h00;
            dir_q      <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_last_q  <= 1'b0;
            rk_out_q   <= '0;
            rk_index_q <= 4'd0;
        end else if (load) begin
            for (int j = 0; j < NK; j++) begin
                w_q[6'(j)] <= key_in[KEY_BITS-1-32*j -: 32];
            end
            state_q    <= S_EXPAND;
            i_q        <= 6'(NK);
            mod_q      <= 3'd0;
            rcon_q     <= 8'h01;
            busy_q     <= 1'b1;
            ready_q    <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_last_q  <= 1'b0;
        end else begin
            case (state_q)
                S_EXPAND: begin
                    w_q[i_q] <= w_new;
                    mod_q    <= (mod_q == 3'(NK-1)) ? 3'd0 : mod_q + 3'd1;
                    if (mod_q == 3'd0) begin
                        rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                    end
                    if (i_q == 6'(NW-1)) begin
                        state_q <= S_READY;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        i_q <= i_q + 6'd1;
                    end
                end
                S_READY: begin
                    if (rd_start) begin
                        state_q    <= S_READ;
                        dir_q      <= rd_dir;
                        ready_q    <= 1'b0;
                        rk_valid_q <= 1'b1;
                        rk_out_q   <= rd_key;
                        rk_index_q <= rd_round;
                        rk_last_q  <= 1'b0;
                    end
                end
                S_READ: begin
                    if (rk_valid_q && rk_ready) begin
                        if (rk_last_q) begin
                            rk_valid_q <= 1'b0;
                            rk_last_q  <= 1'b0;
`ifdef AES_KEY_ZEROIZE_EN
                            for (int j = 0; j < NW; j++) begin
                                w_q[6'(j)] <= '0;
                            end
                            rk_out_q <= '0;
                            state_q  <= S_IDLE;
                            ready_q  <= 1'b0;
`else
                            state_q  <= S_READY;
                            ready_q  <= 1'b1;
`endif
                        end else begin
                            rk_out_q   <= rd_key;
                            rk_index_q <= rd_round;
                            rk_last_q  <= rd_is_last;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = busy_q;
    assign ready    = ready_q;
    assign rk_valid = rk_valid_q;
    assign rk_out   = rk_out_q;
    assign rk_index = rk_index_q;
    assign rk_last  = rk_last_q;

endmodule
